// File: rtl/ctrl_pkg.sv
// Shared opcode, control-word layout and bubble constants for the control pipeline.
package ctrl_pkg;

  localparam int CW_W = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int CW_OPC_LSB    = 0;
  localparam int CW_F3_LSB     = 7;
  localparam int CW_F7_LSB     = 10;
  localparam int CW_ALU_IMM    = 17;
  localparam int CW_MEM_WRITE  = 18;
  localparam int CW_MEM_ACCESS = 19;
  localparam int CW_REG_WRITE  = 20;
  localparam int CW_VALID      = 21;
  localparam int CW_RD_LSB     = 22;

  localparam logic [CW_W-1:0] CW_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of opcode/funct/rd into a control word plus
// illegal and source-register-usage flags.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rd,
  output logic [CW_W-1:0] cw,
  output logic            illegal,
  output logic            rs1_used,
  output logic            rs2_used
);

  logic [3:0] flags;
  logic       known;

  // flags are {reg_write, mem_access, mem_write, alu_imm}
  always_comb begin
    flags    = 4'b0000;
    known    = 1'b1;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OP_R:                    begin flags = 4'b1000; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_I, OP_JALR:           begin flags = 4'b1001; rs1_used = 1'b1; end
      OP_LOAD:                 begin flags = 4'b1101; rs1_used = 1'b1; end
      OP_STORE:                begin flags = 4'b0111; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_BRANCH:               begin flags = 4'b0000; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL: flags = 4'b1001;
      default:                 known = 1'b0;
    endcase

    cw = CW_BUBBLE;
    if (known) begin
      cw[CW_OPC_LSB +: 7]  = opcode;
      cw[CW_F3_LSB +: 3]   = funct3;
      cw[CW_F7_LSB +: 7]   = funct7;
      cw[CW_REG_WRITE]     = flags[3];
      cw[CW_MEM_ACCESS]    = flags[2];
      cw[CW_MEM_WRITE]     = flags[1];
      cw[CW_ALU_IMM]       = flags[0];
      cw[CW_VALID]         = 1'b1;
      cw[CW_RD_LSB +: 5]   = flags[3] ? rd : 5'd0;
    end
    illegal = !known;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline: handshake, stall, branch flush and illegal-op pulse.
// Define CTRL_PIPE_HAZARD_EN to compile in load-use hazard detection.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [4:0]            rd,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic [CW_W*DEPTH-1:0] cw_stage,
  output logic                  illegal_op,
  output logic                  hazard_stall
);

  logic [CW_W-1:0] stage_q [DEPTH];
  logic [CW_W-1:0] dec_cw;
  logic            dec_illegal;
  logic            rs1_used;
  logic            rs2_used;

  ctrl_decode u_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .rd       (rd),
    .cw       (dec_cw),
    .illegal  (dec_illegal),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

`ifdef CTRL_PIPE_HAZARD_EN
  logic [4:0] load_rd;
  assign load_rd = stage_q[0][CW_RD_LSB +: 5];

  // A load sitting in stage 0 whose result a decoding instruction needs
  assign hazard_stall = stage_q[0][CW_VALID] && stage_q[0][CW_REG_WRITE] &&
                        stage_q[0][CW_MEM_ACCESS] && (load_rd != 5'd0) &&
                        ((rs1_used && (rs1 == load_rd)) || (rs2_used && (rs2 == load_rd)));
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{rs1, rs2, rs1_used, rs2_used};
  assign hazard_stall = 1'b0;
`endif

  assign in_ready = !stall_in && !hazard_stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= CW_BUBBLE;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= in_valid && in_ready && dec_illegal && !flush;
      // Flush wins over both stall sources in the young stages
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (flush && (k < FLUSH_DEPTH)) stage_q[k] <= CW_BUBBLE;
        else if (!stall_in)             stage_q[k] <= stage_q[k-1];
      end
      if (flush)          stage_q[0] <= CW_BUBBLE;
      else if (!stall_in) stage_q[0] <= (in_valid && !hazard_stall) ? dec_cw : CW_BUBBLE;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign cw_stage[CW_W*g +: CW_W] = stage_q[g];
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe (DEPTH=4, FLUSH_DEPTH=2) against a
// table-driven reference model of the decode and stage-movement rules.
module tb_ctrl_pipe;

  localparam int D  = 4;
  localparam int FD = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [4:0]    rs1, rs2, rd;
  logic          stall_in;
  logic          flush;
  logic [32*D-1:0] cw_stage;
  logic          illegal_op;
  logic          hazard_stall;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_st [D];
  logic        m_ill;

  ctrl_pipe #(.DEPTH(D), .FLUSH_DEPTH(FD)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .stall_in     (stall_in),
    .flush        (flush),
    .cw_stage     (cw_stage),
    .illegal_op   (illegal_op),
    .hazard_stall (hazard_stall)
  );

  always #5 clock = ~clock;

  // Reference decode: table of {reg_write, mem_access, mem_write, alu_imm}
  function automatic logic [31:0] ref_word(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] d);
    logic [3:0] f;
    if (op == 7'b0110011) f = 4'b1000;
    else if (op inside {7'b0010011, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111}) f = 4'b1001;
    else if (op == 7'b0000011) f = 4'b1101;
    else if (op == 7'b0100011) f = 4'b0111;
    else if (op == 7'b1100011) f = 4'b0000;
    else return 32'h0;
    return {5'b0, (f[3] ? d : 5'd0), 1'b1, f, f7, f3, op};
  endfunction

  function automatic logic ref_known(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return ref_known(op) && !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic logic ref_hazard();
`ifdef CTRL_PIPE_HAZARD_EN
    logic [31:0] w;
    logic [4:0]  ld;
    w  = m_st[0];
    ld = w[26:22];
    return w[21] && w[20] && w[19] && (ld != 5'd0) &&
           ((uses_rs1(opcode) && rs1 == ld) || (uses_rs2(opcode) && rs2 == ld));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [6:0] pick_op(input int i);
    case (i)
      0: return 7'b0110011;  1: return 7'b0010011;  2: return 7'b0000011;
      3: return 7'b0100011;  4: return 7'b1100011;  5: return 7'b1100111;
      6: return 7'b0110111;  7: return 7'b0010111;  8: return 7'b1101111;
      default: return 7'($urandom);
    endcase
  endfunction

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] d, input logic st, input logic fl);
    in_valid = v; opcode = op; funct3 = f3; funct7 = f7;
    rs1 = a; rs2 = b; rd = d; stall_in = st; flush = fl;
    #1;
  endtask

  // Advance model and DUT by one clock edge
  task automatic tick();
    logic [31:0] nxt [D];
    logic        hz, acc;
    hz  = ref_hazard();
    acc = in_valid && !stall_in && !hz && !flush;
    for (int k = 0; k < D; k++) begin
      if (flush && k < FD) nxt[k] = 32'h0;
      else if (stall_in)   nxt[k] = m_st[k];
      else if (k == 0)     nxt[k] = (in_valid && !hz) ? ref_word(opcode, funct3, funct7, rd) : 32'h0;
      else                 nxt[k] = m_st[k-1];
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < D; k++) m_st[k] = nxt[k];
    m_ill = acc && !ref_known(opcode);
  endtask

  task automatic idle();
    applyStimulus(0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < D; k++) begin
      checks++;
      if (cw_stage[32*k +: 32] !== 32'h0) begin
        failures++; $display("[TB] FAIL reset_stage%0d got=%h exp=0", k, cw_stage[32*k +: 32]);
      end
    end
    checks++;
    if (illegal_op !== 1'b0 || hazard_stall !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_flags got ill=%b hz=%b rdy=%b exp 0 0 1",
                           illegal_op, hazard_stall, in_ready);
    end
    #2 reset = 1'b1;
    @(posedge clock); #1;
    idle(); tick();
    checks++;
    if (cw_stage !== '0) begin
      failures++; $display("[TB] FAIL reset_idle got=%h exp=0", cw_stage);
    end
  endtask

  task automatic test_rtype_latency();
    logic [31:0] w;
    w = ref_word(7'b0110011, 3'b000, 7'b0, 5'd5);
    applyStimulus(1, 7'b0110011, 3'b000, 7'b0, 5'd1, 5'd2, 5'd5, 0, 0);
    tick();
    checks++;
    if (cw_stage[21] !== 1'b1 || cw_stage[20] !== 1'b1 || cw_stage[26:22] !== 5'd5 || cw_stage[31:0] !== w) begin
      failures++; $display("[TB] FAIL rtype_stage0 got=%h exp=%h", cw_stage[31:0], w);
    end
    for (int i = 0; i < 3; i++) begin idle(); tick(); end
    checks++;
    if (cw_stage[127:96] !== w) begin
      failures++; $display("[TB] FAIL rtype_stage3 got=%h exp=%h", cw_stage[127:96], w);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] ld_w, r_w;
    logic        exp_hz;
`ifdef CTRL_PIPE_HAZARD_EN
    exp_hz = 1'b1;
`else
    exp_hz = 1'b0;
`endif
    ld_w = ref_word(7'b0000011, 3'b010, 7'b0, 5'd7);
    r_w  = ref_word(7'b0110011, 3'b000, 7'b0, 5'd9);
    applyStimulus(1, 7'b0000011, 3'b010, 7'b0, 5'd1, 5'd0, 5'd7, 0, 0);
    tick();
    applyStimulus(1, 7'b0110011, 3'b000, 7'b0, 5'd3, 5'd7, 5'd9, 0, 0);
    checks++;
    if (hazard_stall !== exp_hz || in_ready !== !exp_hz) begin
      failures++; $display("[TB] FAIL hazard_raise got hz=%b rdy=%b exp hz=%b", hazard_stall, in_ready, exp_hz);
    end
    tick();
    checks++;
    if (cw_stage[31:0] !== (exp_hz ? 32'h0 : r_w) || cw_stage[63:32] !== ld_w) begin
      failures++; $display("[TB] FAIL hazard_bubble got s0=%h s1=%h", cw_stage[31:0], cw_stage[63:32]);
    end
    checks++;
    if (hazard_stall !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL hazard_clear got hz=%b rdy=%b exp 0 1", hazard_stall, in_ready);
    end
    tick();
    checks++;
    if (cw_stage[31:0] !== r_w || cw_stage[31:0] !== m_st[0]) begin
      failures++; $display("[TB] FAIL hazard_accept got=%h exp=%h", cw_stage[31:0], r_w);
    end
  endtask

  task automatic test_no_hazard_rd0();
    logic [31:0] ld_w, r_w;
    ld_w = ref_word(7'b0000011, 3'b010, 7'b0, 5'd0);
    r_w  = ref_word(7'b0110011, 3'b000, 7'b0, 5'd4);
    applyStimulus(1, 7'b0000011, 3'b010, 7'b0, 5'd1, 5'd0, 5'd0, 0, 0);
    tick();
    applyStimulus(1, 7'b0110011, 3'b000, 7'b0, 5'd0, 5'd0, 5'd4, 0, 0);
    checks++;
    if (hazard_stall !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL rd0_nohazard got hz=%b rdy=%b exp 0 1", hazard_stall, in_ready);
    end
    tick();
    checks++;
    if (cw_stage[31:0] !== r_w || cw_stage[63:32] !== ld_w) begin
      failures++; $display("[TB] FAIL rd0_b2b got s0=%h s1=%h exp %h %h", cw_stage[31:0], cw_stage[63:32], r_w, ld_w);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < D; i++) begin
      applyStimulus(1, 7'b0110011, 3'(i), 7'b0, 5'd1, 5'd2, 5'(11 + i), 0, 0);
      tick();
    end
  endtask

  task automatic test_flush();
    logic [31:0] old [D];
    fill();
    for (int k = 0; k < D; k++) old[k] = m_st[k];
    applyStimulus(1, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd15, 0, 1);
    tick();
    checks++;
    if (cw_stage[31:0] !== 32'h0 || cw_stage[63:32] !== 32'h0 ||
        cw_stage[95:64] !== old[1] || cw_stage[127:96] !== old[2]) begin
      failures++; $display("[TB] FAIL flush_move got=%h exp s2=%h s3=%h", cw_stage, old[1], old[2]);
    end
  endtask

  task automatic test_stall();
    logic [31:0] old [D];
    fill();
    for (int k = 0; k < D; k++) old[k] = m_st[k];
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 7'b0010011, 3'd1, 7'd0, 5'd3, 5'd3, 5'd3, 1, 0);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("[TB] FAIL stall_ready cyc%0d got=%b exp=0", i, in_ready);
      end
      tick();
      for (int k = 0; k < D; k++) begin
        checks++;
        if (cw_stage[32*k +: 32] !== old[k]) begin
          failures++; $display("[TB] FAIL stall_hold cyc%0d s%0d got=%h exp=%h", i, k, cw_stage[32*k +: 32], old[k]);
        end
      end
    end
    applyStimulus(1, 7'b0010011, 3'd1, 7'd0, 5'd3, 5'd3, 5'd3, 1, 1);
    tick();
    checks++;
    if (cw_stage[63:0] !== 64'h0 || cw_stage[95:64] !== old[2] || cw_stage[127:96] !== old[3]) begin
      failures++; $display("[TB] FAIL stall_flush got=%h exp s2=%h s3=%h", cw_stage, old[2], old[3]);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] prev0;
    prev0 = m_st[0];
    applyStimulus(1, 7'b1111111, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 0, 0);
    tick();
    checks++;
    if (cw_stage[31:0] !== 32'h0 || illegal_op !== 1'b1 || cw_stage[63:32] !== prev0) begin
      failures++; $display("[TB] FAIL illegal_pulse got s0=%h ill=%b exp 0 1", cw_stage[31:0], illegal_op);
    end
    idle(); tick();
    checks++;
    if (illegal_op !== 1'b0) begin
      failures++; $display("[TB] FAIL illegal_width got=%b exp=0", illegal_op);
    end
    applyStimulus(1, 7'b1111111, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 0, 1);
    tick();
    checks++;
    if (illegal_op !== 1'b0) begin
      failures++; $display("[TB] FAIL illegal_flushed got=%b exp=0", illegal_op);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), pick_op($urandom_range(0, 10)), 3'($urandom),
                    7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      checks++;
      if (hazard_stall !== ref_hazard() || in_ready !== (!stall_in && !ref_hazard())) begin
        failures++; $display("[TB] FAIL rand_comb cyc%0d got hz=%b rdy=%b exp hz=%b", i, hazard_stall, in_ready, ref_hazard());
      end
      tick();
      checks++;
      if (illegal_op !== m_ill) begin
        failures++; $display("[TB] FAIL rand_illegal cyc%0d got=%b exp=%b", i, illegal_op, m_ill);
      end
      for (int k = 0; k < D; k++) begin
        checks++;
        if (cw_stage[32*k +: 32] !== m_st[k]) begin
          failures++; $display("[TB] FAIL rand_stage cyc%0d s%0d got=%h exp=%h", i, k, cw_stage[32*k +: 32], m_st[k]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    fill();
    applyStimulus(1, 7'b1111111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    tick();
    idle();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (cw_stage !== '0 || illegal_op !== 1'b0 || hazard_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL async_reset got cw=%h ill=%b hz=%b exp all 0", cw_stage, illegal_op, hazard_stall);
    end
    for (int k = 0; k < D; k++) m_st[k] = 32'h0;
    m_ill = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    idle(); tick();
    checks++;
    if (cw_stage !== '0) begin
      failures++; $display("[TB] FAIL async_release got=%h exp=0", cw_stage);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b0;
    for (int k = 0; k < D; k++) m_st[k] = 32'h0;
    m_ill = 1'b0;
    in_valid = 0; opcode = 0; funct3 = 0; funct7 = 0;
    rs1 = 0; rs2 = 0; rd = 0; stall_in = 0; flush = 0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_rtype_latency();
    test_hazard();
    test_no_hazard_rd0();
    test_flush();
    test_stall();
    test_illegal();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
